fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Decoupled instruction fetch stage: owns the fetch PC, issues word fetches over a
//  valid/ready request + in-order response bus, and buffers returned words with their PC
//  in a prefetch queue for decode. Supports several outstanding requests and
//  redirect/flush from branches and jumps. Supersedes the PC/IR registers of the multicycle datapath.
// PARAMETERS
//  XLEN            32            address/instruction width
//  RESET_PC        32'h00010000  fetch PC after reset
//  QUEUE_DEPTH     4             prefetch queue entries (>=2, power of 2)
//  MAX_OUTSTANDING 2             max requests accepted without a response (>=1)
// PORTS
//  clk_i            in   1     clock
//  reset_ni         in   1     reset, asynchronous assert, active-low
//  mem_req_valid_o  out  1     fetch request valid
//  mem_req_ready_i  in   1     memory accepts request (accepted on valid&&ready)
//  mem_req_addr_o   out  XLEN  word-aligned fetch address
//  mem_rsp_valid_i  in   1     response valid, in request order, no backpressure
//  mem_rsp_data_i   in   XLEN  fetched word
//  mem_rsp_err_i    in   1     bus error for this response
//  instr_valid_o    out  1     queue head valid
//  instr_ready_i    in   1     decode consumes head on valid&&ready
//  instr_o          out  XLEN  head instruction word
//  instr_pc_o       out  XLEN  head PC
//  instr_fault_o    out  1     head fetched with bus error
//  redirect_i       in   1     flush and restart fetch
//  redirect_pc_i    in   XLEN  new fetch PC ([1:0] forced to 0)
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0; all outputs 0 except
//    mem_req_addr_o=RESET_PC. First request valid the cycle after reset deasserts.
//  - Issue: mem_req_valid_o = !redirect_i && outstanding<MAX_OUTSTANDING &&
//    (count+outstanding)<QUEUE_DEPTH && drop==0. Credit scheme: responses never overflow queue.
//  - valid need not stay high until ready (may drop on redirect). On accept: fetch_pc+=4,
//    outstanding+=1. PC wraps modulo 2^XLEN silently.
//  - Response: outstanding-=1. If drop>0: discard, drop-=1. Else push {pc,data,err}; entry pc
//    comes from an issued-PC tracker (oldest outstanding address), not recomputed.
//  - Accept and response in same cycle: outstanding unchanged.
//  - Pop on instr_valid_o&&instr_ready_i. Push into empty queue visible next cycle (1-cycle
//    latency rsp->instr_valid_o); simultaneous push+pop at full legal (count unchanged).
//  - Err entry: data passed as-is, instr_fault_o=1; fetch continues (decode raises trap).
//  - Redirect (highest priority): queue flushed; fetch_pc<=redirect_pc_i&~3; drop<=outstanding
//    minus 1 if a response arrives that cycle (that response discarded); no request issued;
//    pop ignored. Next cycle may issue if drop==0, else wait for drop==0.
//  - Redirect back-to-back: each recomputes drop from current outstanding; last PC wins.
//  - Reset mid-transfer: all state cleared; memory side is reset by the same reset.
//  - Counter widths: $clog2(QUEUE_DEPTH+1), $clog2(MAX_OUTSTANDING+1).
// STRUCTURE
//  - Package definitions: fetch_entry_t {pc, instr, fault}; RESET_PC default constant.
//  - Sub-module fetch_queue: sync FIFO of fetch_entry_t, push/pop/flush, count output,
//    flush dominant over push.
//  - Top: PC register, outstanding/drop counters, small issued-PC FIFO (MAX_OUTSTANDING).
// TESTING
//  1 Reset, ready=1, rsp 1 cycle later, decode ready -> instr_pc 0x10000,0x10004,0x10008
//    in order, no gaps after pipeline fill.
//  2 instr_ready_i=0 with QUEUE_DEPTH=4 -> exactly 4 requests accepted, then valid low;
//    one pop -> exactly one more request.
//  3 Two outstanding (0x10000,0x10004), redirect to 0x20002 -> both responses dropped, next
//    request 0x20000, first instr_pc_o 0x20000.
//  4 Redirect same cycle as response -> that response not enqueued, drop=outstanding-1.
//  5 mem_rsp_err_i=1 on second word -> instr_fault_o=1 only for pc 0x10004, fetch continues.
//  6 fetch_pc 0xFFFFFFFC accepted -> next request 0x00000000; reset_ni low mid-burst ->
//    instr_valid_o=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit_pkg : shared types and constants for the fetch stage
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0001_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] pc);
    return pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit_if : memory request/response bus plus decode-side handshake
// Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_unit_if;

  logic                          mem_req_valid_o;
  logic                          mem_req_ready_i;
  logic [fetch_unit_pkg::XLEN-1:0] mem_req_addr_o;
  logic                          mem_rsp_valid_i;
  logic [fetch_unit_pkg::XLEN-1:0] mem_rsp_data_i;
  logic                          mem_rsp_err_i;
  logic                          instr_valid_o;
  logic                          instr_ready_i;
  logic [fetch_unit_pkg::XLEN-1:0] instr_o;
  logic [fetch_unit_pkg::XLEN-1:0] instr_pc_o;
  logic                          instr_fault_o;
  logic                          redirect_i;
  logic [fetch_unit_pkg::XLEN-1:0] redirect_pc_i;

  modport master (
    output mem_req_valid_o, mem_req_addr_o,
    output instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    input  instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_addr_o,
    input  instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    output instr_ready_i, redirect_i, redirect_pc_i
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : synchronous FIFO of fetch entries, flush dominates push
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       push_i,
  input  fetch_entry_t               entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  slot_q [DEPTH];
  fetch_entry_t  slot_d [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A pop frees the slot the same cycle, so push into a full queue is legal then.
  assign push_ok = push_i && ((count_q != FULL) || pop_ok);

  always_comb begin
    slot_d  = slot_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        slot_d[wptr_q] = entry_i;
        wptr_d         = wptr_q + PW'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slot_q  <= '{default: '0};
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot_q[rptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : decoupled fetch stage, credit-limited issue with prefetch queue
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(QUEUE_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   out_q, out_d, drop_q, drop_d;
  logic            run_q, run_d;
  logic [XLEN-1:0] trk_q [MAX_OUTSTANDING];
  logic [XLEN-1:0] trk_d [MAX_OUTSTANDING];
  logic [TW-1:0]   trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;

  logic [CW-1:0]   q_count;
  logic            q_valid;
  fetch_entry_t    q_head, q_in;
  logic            req_valid, accept, rsp, push, pop;

  function automatic logic [TW-1:0] trk_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Reserving queue space for every in-flight request keeps responses from ever overflowing.
  assign req_valid = run_q && !bus.redirect_i && (out_q < MAX_OUT) &&
                     ((SW'(q_count) + SW'(out_q)) < DEPTH_S) && (drop_q == '0);
  assign accept    = req_valid && bus.mem_req_ready_i;
  assign rsp       = bus.mem_rsp_valid_i;
  assign push      = rsp && (drop_q == '0) && !bus.redirect_i;
  assign pop       = q_valid && bus.instr_ready_i && !bus.redirect_i;

  assign q_in = '{pc: trk_q[trk_rd_q], instr: bus.mem_rsp_data_i, fault: bus.mem_rsp_err_i};

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q + OW'(accept) - OW'(rsp);
    drop_d   = drop_q;
    run_d    = 1'b1;
    trk_d    = trk_q;
    trk_wr_d = trk_wr_q;
    trk_rd_d = trk_rd_q;
    if (accept) begin
      trk_d[trk_wr_q] = pc_q;
      trk_wr_d        = trk_next(trk_wr_q);
      pc_d            = pc_q + XLEN'(4);
    end
    // Dropped responses still retire their tracker slot to keep it aligned.
    if (rsp) begin
      trk_rd_d = trk_next(trk_rd_q);
    end
    if (bus.redirect_i) begin
      pc_d   = align_word(bus.redirect_pc_i);
      drop_d = out_q - OW'(rsp);
    end else if (rsp && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      run_q    <= 1'b0;
      trk_q    <= '{default: '0};
      trk_wr_q <= '0;
      trk_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      run_q    <= run_d;
      trk_q    <= trk_d;
      trk_wr_q <= trk_wr_d;
      trk_rd_q <= trk_rd_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push),
    .entry_i  (q_in),
    .pop_i    (pop),
    .flush_i  (bus.redirect_i),
    .head_o   (q_head),
    .valid_o  (q_valid),
    .count_o  (q_count)
  );

  assign bus.mem_req_valid_o = req_valid;
  assign bus.mem_req_addr_o  = pc_q;
  assign bus.instr_valid_o   = q_valid;
  assign bus.instr_o         = q_valid ? q_head.instr : '0;
  assign bus.instr_pc_o      = q_valid ? q_head.pc    : '0;
  assign bus.instr_fault_o   = q_valid && q_head.fault;

endmodule
`default_nettype wire
